// File: rtl/maint_pkg.sv
// maint_pkg: state encoding and default sizes shared by the maintenance log reader and writer.
package maint_pkg;
  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, PRESENT, FINISH} state_t;
endpackage

// File: rtl/maint_log_reader.sv
// maint_log_reader: dumps log_count entries from an external 1-cycle-latency log memory
// to a valid/ready consumer, one entry per fetch/capture/present round.
module maint_log_reader
  import maint_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] log_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              busy,
  output logic              done
);
  state_t            r_state;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_cnt_q;
  logic [DATA_W-1:0] r_dump_data;
  logic              r_dump_valid;
  logic              r_mem_en;
  logic              r_done;
  logic              w_last;
  assign w_last     = r_rd_ptr == r_cnt_q - 1'b1;
  assign mem_addr   = r_rd_ptr;
  assign mem_en     = r_mem_en;
  assign dump_data  = r_dump_data;
  assign dump_valid = r_dump_valid;
  assign done       = r_done;
  assign busy       = r_state != IDLE;
  // mem_en and done are pulses: cleared every cycle unless the transition re-arms them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_rd_ptr     <= '0;
      r_cnt_q      <= '0;
      r_dump_data  <= '0;
      r_dump_valid <= 1'b0;
      r_mem_en     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_mem_en <= 1'b0;
      r_done   <= 1'b0;
      if (abort && r_state != IDLE) begin
        r_state      <= IDLE;
        r_dump_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (start) begin
            if (log_count != '0) begin
              r_cnt_q  <= log_count;
              r_rd_ptr <= '0;
              r_mem_en <= 1'b1;
              r_state  <= FETCH;
            end else r_done <= 1'b1;
          end
          FETCH: r_state <= CAPTURE;
          CAPTURE: begin
            r_dump_data  <= mem_rd_data;
            r_dump_valid <= 1'b1;
            r_state      <= PRESENT;
          end
          PRESENT: if (r_dump_valid && dump_ready) begin
            r_dump_valid <= 1'b0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= FINISH;
            end else begin
              r_rd_ptr <= r_rd_ptr + 1'b1;
              r_mem_en <= 1'b1;
              r_state  <= FETCH;
            end
          end
          FINISH: r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_maint_log_reader.sv
// tb_maint_log_reader: directed and randomized dumps checked against an expected
// entry stream built from the memory image and the handshake/latency rules.
module tb_maint_log_reader;
  localparam int AW = 11;
  localparam int DW = 8;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] log_count = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_en;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] dump_data;
  logic          dump_valid;
  logic          dump_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [DW-1:0] mem [0:2047];
  int total = 0;
  int bad = 0;

  maint_log_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .log_count(log_count),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_rd_data(mem_rd_data),
    .dump_data(dump_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // external log memory: data appears one cycle after a read enable
  always @(posedge clk) if (mem_en) mem_rd_data <= mem[mem_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one dump of n entries. pct: chance (%) of ready per cycle; hold: cycles ready
  // is forced low on entry 0; abort_hs: handshake index at which abort is raised (-1 none);
  // restart_at: cycle in which a stray start with a different count is issued (-1 none).
  task automatic run_dump(input int n, input int pct, input int hold, input int abort_hs,
                          input int restart_at);
    int idx = 0, fetches = 0, last_hs = -1, prev_hs = -1, first_valid = -1, held = 0, max_addr = 0;
    bit fin = 0;
    start = 1'b1;
    log_count = AW'(n);
    dump_ready = 1'b0;
    for (int c = 1; c <= 3 * n + 40 && !fin; c++) begin
      tick;
      start = 1'b0;
      if (c == restart_at) begin
        start = 1'b1;
        log_count = AW'(n + 7);
      end
      if (mem_en) begin
        fetches++;
        chk("fetch_addr", int'(mem_addr), idx);
        if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
      end
      if (dump_valid) begin
        if (first_valid < 0) begin
          first_valid = c;
          chk("first_valid_latency", c, 3);
        end
        chk("dump_data", int'(dump_data), int'(mem[idx]));
        chk("mem_en_while_valid", int'(mem_en), 0);
      end
      if (done) begin
        chk("done_entries", idx, n);
        chk("done_after_last_hs", c, last_hs + 1);
        chk("busy_in_finish", int'(busy), 1);
        fin = 1;
      end
      dump_ready = ($urandom_range(99) < pct);
      if (dump_valid && idx == 0 && held < hold) begin
        dump_ready = 1'b0;
        held++;
      end
      if (dump_valid && dump_ready) begin
        if (idx == abort_hs) begin
          abort = 1'b1;
          tick;
          abort = 1'b0;
          dump_ready = 1'b0;
          chk("abort_valid", int'(dump_valid), 0);
          chk("abort_busy", int'(busy), 0);
          chk("abort_done", int'(done), 0);
          for (int k = 0; k < 3; k++) begin
            tick;
            chk("post_abort_quiet", int'(done | mem_en | busy), 0);
          end
          return;
        end
        if (pct == 100 && hold == 0 && prev_hs >= 0) chk("throughput", c - prev_hs, 3);
        prev_hs = c;
        last_hs = c;
        idx++;
      end
    end
    chk("dump_completed", int'(fin), 1);
    chk("fetch_count", fetches, n);
    chk("max_addr", max_addr, n - 1);
    dump_ready = 1'b0;
    tick;
    chk("idle_after_done", int'(busy | done | dump_valid), 0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = DW'($urandom);
    mem[0] = 8'hA1;
    mem[1] = 8'hB2;
    mem[2] = 8'hC3;
    #1;
    chk("rst_valid", int'(dump_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mem_en", int'(mem_en), 0);
    chk("rst_data", int'(dump_data), 0);
    tick;
    reset = 1'b1;
    tick;
    // three fixed bytes at full throughput
    run_dump(3, 100, 0, -1, -1);
    // empty log: done pulse only, no memory access
    start = 1'b1;
    log_count = '0;
    tick;
    start = 1'b0;
    chk("empty_done", int'(done), 1);
    chk("empty_busy", int'(busy), 0);
    chk("empty_mem_en", int'(mem_en), 0);
    tick;
    chk("empty_done_pulse", int'(done), 0);
    chk("empty_quiet", int'(busy | mem_en), 0);
    // consumer stalls entry 0 for 5 cycles
    run_dump(2, 100, 5, -1, -1);
    // abort on the second handshake, then restart from address 0
    run_dump(4, 100, 0, 1, -1);
    run_dump(4, 100, 0, -1, -1);
    // asynchronous reset in CAPTURE
    start = 1'b1;
    log_count = AW'(3);
    tick;
    start = 1'b0;
    tick;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_quiet", int'(dump_valid | done | mem_en), 0);
    chk("async_rst_addr", int'(mem_addr), 0);
    chk("async_rst_data", int'(dump_data), 0);
    tick;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("no_resume", int'(busy | mem_en | dump_valid | done), 0);
    end
    // stray start with a different count mid-dump
    run_dump(5, 100, 0, -1, 4);
    run_dump(5, 50, 0, -1, 8);
    for (int r = 0; r < 6; r++) run_dump(int'($urandom_range(1, 20)), 60, 0, -1, -1);
    // largest log: address must climb to 2046 without wrapping
    run_dump(2047, 100, 0, -1, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
